kf8259_interrupt_acknowledge_master: RTL and testbench
======================================================

Name: kf8259_interrupt_acknowledge_master

Overview:
- CPU-side counterpart of the 8259 interrupt controller: it initiates the interrupt acknowledge protocol that the controller answers.
- It samples INT, runs the two-pulse INTA# bus sequence with LOCK# held across both pulses, and captures the vector byte the controller drives during the second pulse.
- It sits between the CPU core's instruction-boundary logic and the 8259 bus interface, and hands a valid vector to the core.

Parameters:
- INTA_LOW_CYCLES, 4, clocks INTA# is held low per pulse (>=1)
- INTA_GAP_CYCLES, 2, clocks INTA# is high between the pulses, and recovery clocks after the second pulse (>=1)

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- interrupt  input  1  INT from 8259, asynchronous to the core, active high
- interrupt_enable  input  1  CPU IF flag
- accept_strobe  input  1  one-cycle pulse from the core at an instruction boundary
- data_bus_in  input  8  8259 data bus output (vector byte)
- interrupt_acknowledge_n  output  1  INTA# to the 8259
- bus_lock_n  output  1  LOCK#, active low
- vector  output  8  captured interrupt vector
- vector_valid  output  1  one-cycle pulse: vector is new
- busy  output  1  sequence in progress

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: interrupt_acknowledge_n=1, bus_lock_n=1, vector=8'h00, vector_valid=0, busy=0, state=IDLE, counter=0, synchronizer flops=0.
- Synchronizer: interrupt passes through a 2-flop synchronizer. interrupt_sync reflects the pin 2 clocks later. Only interrupt_sync is used internally.
- Counter: a single down-counter, wide enough for max(INTA_LOW_CYCLES, INTA_GAP_CYCLES)-1.
- IDLE:
  - Go to INTA1 when interrupt_sync & interrupt_enable & accept_strobe, all sampled at edge E0.
  - At E0 also register: interrupt_acknowledge_n<=0, bus_lock_n<=0, busy<=1, counter<=INTA_LOW_CYCLES-1.
  - Otherwise stay in IDLE; accept_strobe has no effect.
- INTA1:
  - Decrement the counter.
  - At counter==0: interrupt_acknowledge_n<=1, counter<=INTA_GAP_CYCLES-1, go to GAP. bus_lock_n stays 0.
- GAP:
  - Decrement the counter.
  - At 0: interrupt_acknowledge_n<=0, counter<=INTA_LOW_CYCLES-1, go to INTA2.
- INTA2:
  - Decrement the counter.
  - At 0: vector<=data_bus_in (sampled at this edge), vector_valid<=1, interrupt_acknowledge_n<=1, bus_lock_n<=1, counter<=INTA_GAP_CYCLES-1, go to RECOVER.
- RECOVER:
  - vector_valid is forced back to 0 after one cycle.
  - Decrement the counter; at 0: busy<=0, go to IDLE.
- Timing with defaults, edges counted from E0:
  - INTA# low E0..E4, high E4..E6, low E6..E10.
  - Vector sampled at E10; vector_valid high E10..E11.
  - LOCK# low E0..E10; busy high E0..E12.
  - Total sequence: 2*INTA_LOW_CYCLES + 2*INTA_GAP_CYCLES clocks.
- Boundary conditions:
  - interrupt drops mid-sequence: the sequence completes unchanged and the vector is whatever the 8259 drives (its spurious IR7 vector). No abort.
  - interrupt_enable drops mid-sequence: no effect; it is checked only in IDLE.
  - interrupt still high on return to IDLE: a new sequence starts only on a fresh accept_strobe meeting all IDLE conditions. No back-to-back start in the cycle busy falls.
  - accept_strobe while busy: ignored, not queued.
  - reset_n asserted mid-sequence: all outputs return to reset values immediately (asynchronously). INTA# and LOCK# go high with no partial-pulse completion, and vector is cleared.
  - Outputs are registered only; no combinational path from inputs to outputs.
  - vector holds its value until the next capture.

Test Plan:
- Reset: hold reset_n=0 with interrupt=1 and accept_strobe pulsing -> INTA#=1, LOCK#=1, busy=0, vector=8'h00 throughout. Release: no sequence until a strobe arrives 2+ clocks after interrupt is high.
- Nominal (defaults): interrupt=1 for 3 clocks, then accept_strobe pulse with IF=1, data_bus_in=8'h0D during the second pulse -> INTA# low 4 / high 2 / low 4 clocks, LOCK# low 10 clocks, vector=8'h0D, vector_valid exactly 1 cycle at E10, busy low at E12.
- Gating: IF=0 or interrupt_sync=0 at the strobe -> no INTA# activity and busy stays 0. Strobe during busy -> exactly two INTA# pulses total.
- Spurious: interrupt drops at E2 -> sequence completes, data_bus_in=8'h0F captured, vector_valid asserts.
- Reset mid-sequence: reset_n=0 at E7 during the second pulse -> INTA#=1, LOCK#=1 within the same cycle, vector=0, vector_valid never asserted. After release, a new strobe runs a full sequence.
- Parameters INTA_LOW_CYCLES=1, INTA_GAP_CYCLES=1: pulse widths 1/1/1, vector captured at E3, busy total 4 clocks.

Source files
------------

// File: rtl/kf8259_interrupt_acknowledge_master_if.sv
// Signal bundle between the interrupt acknowledge master, the CPU core and the 8259 bus.
// The master modport is the acknowledge master; slave is the core/8259 side.
interface kf8259_interrupt_acknowledge_master_if;
  logic       interrupt;
  logic       interrupt_enable;
  logic       accept_strobe;
  logic [7:0] data_bus_in;
  logic       interrupt_acknowledge_n;
  logic       bus_lock_n;
  logic [7:0] vector;
  logic       vector_valid;
  logic       busy;

  modport master (
    input  interrupt,
    input  interrupt_enable,
    input  accept_strobe,
    input  data_bus_in,
    output interrupt_acknowledge_n,
    output bus_lock_n,
    output vector,
    output vector_valid,
    output busy
  );

  modport slave (
    output interrupt,
    output interrupt_enable,
    output accept_strobe,
    output data_bus_in,
    input  interrupt_acknowledge_n,
    input  bus_lock_n,
    input  vector,
    input  vector_valid,
    input  busy
  );
endinterface

// File: rtl/kf8259_interrupt_acknowledge_master.sv
// CPU-side 8259 interrupt acknowledge master: two locked INTA# pulses, vector captured
// at the end of the second pulse and handed to the core with a one-cycle valid strobe.
module kf8259_interrupt_acknowledge_master #(
  parameter int INTA_LOW_CYCLES = 4,
  parameter int INTA_GAP_CYCLES = 2
) (
  input logic clock,
  input logic reset_n,
  kf8259_interrupt_acknowledge_master_if.master ack_bus
);

  localparam int MAX_CYCLES    = (INTA_LOW_CYCLES > INTA_GAP_CYCLES) ? INTA_LOW_CYCLES : INTA_GAP_CYCLES;
  localparam int COUNTER_WIDTH = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [COUNTER_WIDTH-1:0] LOW_RELOAD = COUNTER_WIDTH'(INTA_LOW_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] GAP_RELOAD = COUNTER_WIDTH'(INTA_GAP_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] COUNT_ONE  = COUNTER_WIDTH'(1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] INTA1   = 3'd1;
  localparam logic [2:0] GAP     = 3'd2;
  localparam logic [2:0] INTA2   = 3'd3;
  localparam logic [2:0] RECOVER = 3'd4;

  logic [2:0]               state;
  logic [COUNTER_WIDTH-1:0] counter;
  logic                     interrupt_meta;
  logic                     interrupt_sync;
  logic                     inta_n_q;
  logic                     lock_n_q;
  logic [7:0]               vector_q;
  logic                     vector_valid_q;
  logic                     busy_q;

  // INT is asynchronous to the core clock; only the second flop is ever used.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      interrupt_meta <= 1'b0;
      interrupt_sync <= 1'b0;
    end else begin
      interrupt_meta <= ack_bus.interrupt;
      interrupt_sync <= interrupt_meta;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      counter        <= '0;
      inta_n_q       <= 1'b1;
      lock_n_q       <= 1'b1;
      vector_q       <= 8'h00;
      vector_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (interrupt_sync && ack_bus.interrupt_enable && ack_bus.accept_strobe) begin
            state    <= INTA1;
            inta_n_q <= 1'b0;
            lock_n_q <= 1'b0;
            busy_q   <= 1'b1;
            counter  <= LOW_RELOAD;
          end
        end
        INTA1: begin
          if (counter == '0) begin
            inta_n_q <= 1'b1;
            counter  <= GAP_RELOAD;
            state    <= GAP;
          end else begin
            counter <= counter - COUNT_ONE;
          end
        end
        GAP: begin
          if (counter == '0) begin
            inta_n_q <= 1'b0;
            counter  <= LOW_RELOAD;
            state    <= INTA2;
          end else begin
            counter <= counter - COUNT_ONE;
          end
        end
        INTA2: begin
          // The 8259 drives the vector during the second pulse; take it as the pulse ends.
          if (counter == '0) begin
            vector_q       <= ack_bus.data_bus_in;
            vector_valid_q <= 1'b1;
            inta_n_q       <= 1'b1;
            lock_n_q       <= 1'b1;
            counter        <= GAP_RELOAD;
            state          <= RECOVER;
          end else begin
            counter <= counter - COUNT_ONE;
          end
        end
        RECOVER: begin
          vector_valid_q <= 1'b0;
          if (counter == '0) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            counter <= counter - COUNT_ONE;
          end
        end
        default: begin
          state    <= IDLE;
          counter  <= '0;
          inta_n_q <= 1'b1;
          lock_n_q <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ack_bus.interrupt_acknowledge_n = inta_n_q;
  assign ack_bus.bus_lock_n              = lock_n_q;
  assign ack_bus.vector                  = vector_q;
  assign ack_bus.vector_valid            = vector_valid_q;
  assign ack_bus.busy                    = busy_q;

endmodule

// File: tb/tb_kf8259_interrupt_acknowledge_master.sv
// Bench for kf8259_interrupt_acknowledge_master: a default instance and a 1/1 instance share
// stimulus; expected outputs come from a timeline model (cycles since sequence start).
module tb_kf8259_interrupt_acknowledge_master;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic       pin = 1'b0;
  logic       ie = 1'b0;
  logic       stb = 1'b0;
  logic [7:0] data = 8'h00;

  kf8259_interrupt_acknowledge_master_if if_d ();
  kf8259_interrupt_acknowledge_master_if if_m ();

  assign if_d.interrupt        = pin;
  assign if_d.interrupt_enable = ie;
  assign if_d.accept_strobe    = stb;
  assign if_d.data_bus_in      = data;
  assign if_m.interrupt        = pin;
  assign if_m.interrupt_enable = ie;
  assign if_m.accept_strobe    = stb;
  assign if_m.data_bus_in      = data;

  kf8259_interrupt_acknowledge_master dut_d (
    .clock   (clock),
    .reset_n (reset_n),
    .ack_bus (if_d.master)
  );

  kf8259_interrupt_acknowledge_master #(
    .INTA_LOW_CYCLES (1),
    .INTA_GAP_CYCLES (1)
  ) dut_m (
    .clock   (clock),
    .reset_n (reset_n),
    .ack_bus (if_m.master)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each instance is either idle or k edges into a sequence.
  int         lo [2] = '{4, 1};
  int         gp [2] = '{2, 1};
  bit         act [2];
  int         k [2];
  logic [7:0] vec [2];
  bit         hist [$];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0;
      k[i]   = 0;
      vec[i] = 8'h00;
    end
    hist = '{1'b0, 1'b0};
  endfunction

  function automatic void model_edge();
    bit synced;
    bit was_idle;
    synced = hist[1];
    for (int i = 0; i < 2; i++) begin
      was_idle = !act[i];
      if (act[i]) begin
        k[i]++;
        if (k[i] == 2 * lo[i] + gp[i]) vec[i] = data;
        if (k[i] == 2 * lo[i] + 2 * gp[i]) act[i] = 1'b0;
      end
      if (was_idle && synced && ie && stb) begin
        act[i] = 1'b1;
        k[i]   = 0;
      end
    end
    hist.push_front(pin);
    void'(hist.pop_back());
  endfunction

  task automatic check_outputs();
    logic e_inta, e_lock, e_busy, e_valid;
    string n;
    for (int i = 0; i < 2; i++) begin
      n = (i == 0) ? "d" : "m";
      if (act[i]) begin
        e_inta  = !((k[i] < lo[i]) || (k[i] >= lo[i] + gp[i] && k[i] < 2 * lo[i] + gp[i]));
        e_lock  = !(k[i] < 2 * lo[i] + gp[i]);
        e_busy  = 1'b1;
        e_valid = (k[i] == 2 * lo[i] + gp[i]);
      end else begin
        e_inta  = 1'b1;
        e_lock  = 1'b1;
        e_busy  = 1'b0;
        e_valid = 1'b0;
      end
      check({n, ".inta_n"}, 8'((i == 0) ? if_d.interrupt_acknowledge_n : if_m.interrupt_acknowledge_n), 8'(e_inta));
      check({n, ".lock_n"}, 8'((i == 0) ? if_d.bus_lock_n : if_m.bus_lock_n), 8'(e_lock));
      check({n, ".busy"}, 8'((i == 0) ? if_d.busy : if_m.busy), 8'(e_busy));
      check({n, ".valid"}, 8'((i == 0) ? if_d.vector_valid : if_m.vector_valid), 8'(e_valid));
      check({n, ".vector"}, (i == 0) ? if_d.vector : if_m.vector, vec[i]);
    end
  endtask

  task automatic step();
    @(posedge clock);
    if (reset_n) model_edge();
    else model_reset();
    @(negedge clock);
    check_outputs();
  endtask

  // Called at a negedge: reset lands mid-cycle and must clear outputs without a clock.
  task automatic async_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    pin = 1'b1;
    ie  = 1'b1;
    @(negedge clock);
    repeat (4) begin
      stb = ~stb;
      step();
    end

    // Release: strobes before the synchronizer has seen INT must not start anything.
    reset_n = 1'b1;
    stb = 1'b1;
    repeat (2) step();
    stb = 1'b0;
    repeat (2) step();

    // Nominal sequence with vector 0D.
    data = 8'h0D;
    stb = 1'b1;
    step();
    stb = 1'b0;
    repeat (14) step();

    // Gating: IF low, then INT low at the strobe.
    ie = 1'b0;
    stb = 1'b1;
    step();
    stb = 1'b0;
    ie = 1'b1;
    pin = 1'b0;
    repeat (3) step();
    stb = 1'b1;
    step();
    stb = 1'b0;
    pin = 1'b1;
    repeat (3) step();

    // Strobes while busy are ignored.
    data = 8'h42;
    stb = 1'b1;
    step();
    stb = 1'b0;
    step();
    stb = 1'b1;
    repeat (4) step();
    stb = 1'b0;
    repeat (14) step();

    // Spurious: INT drops at E2, sequence completes with IR7 vector.
    data = 8'h0F;
    stb = 1'b1;
    step();
    stb = 1'b0;
    step();
    step();
    pin = 1'b0;
    repeat (12) step();

    // Reset during the second pulse, then a full sequence after release.
    pin = 1'b1;
    data = 8'h33;
    repeat (3) step();
    stb = 1'b1;
    step();
    stb = 1'b0;
    repeat (7) step();
    async_reset();
    repeat (3) step();
    data = 8'h5A;
    stb = 1'b1;
    step();
    stb = 1'b0;
    repeat (13) step();

    // Randomized traffic with occasional asynchronous resets.
    repeat (800) begin
      if ($urandom_range(0, 15) == 0) pin = ~pin;
      ie   = ($urandom_range(0, 7) != 0);
      stb  = ($urandom_range(0, 3) == 0);
      data = 8'($urandom);
      if ($urandom_range(0, 299) == 0) async_reset();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
